bcd_to_bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter; inverse of the display digit split path.

---
 rtl/bcd_to_bin_seq_pkg.sv | 14 +
 rtl/bcd_to_bin_seq_nibble_adj.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 90 +++++++++
 tb/tb_bcd_to_bin_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants for the BCD-to-binary converter: FSM encodings and nibble thresholds.
// Pure definitions, no logic.
package bcd_to_bin_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] BCD_ADJ_TH = 4'd8;
  localparam logic [3:0] BCD_ADJ    = 4'd3;

endpackage

// File: rtl/bcd_to_bin_seq_nibble_adj.sv
// Reverse double-dabble nibble correction: x >= 8 ? x - 3 : x.
// Combinational, zero latency, no flow control.
module bcd_nibble_adj
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= BCD_ADJ_TH) ? (i_nib - BCD_ADJ) : i_nib;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble); done pulses BIN_W+1 edges after the
// accepting edge, or 1 edge later on a bad digit. Start is ignored while busy; no queueing.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [4*NUM_DIGITS-1:0] i_bcd_in,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [BIN_W-1:0]        o_bin_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  logic [1:0]            r_state;
  logic [SR_W-1:0]       r_sr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;
  logic [BIN_W-1:0]      r_bin_out;

  logic [SR_W-1:0]       w_shifted;
  logic [BCD_W-1:0]      w_bcd_adj;
  logic [NUM_DIGITS-1:0] w_bad;

  assign w_shifted = r_sr >> 1;

  // The BCD field of r_sr holds the captured digits while in LOAD, so the check reads it there.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_nibble_adj u_adj (
      .i_nib (w_shifted[BIN_W+4*g +: 4]),
      .o_nib (w_bcd_adj[4*g +: 4])
    );
    assign w_bad[g] = (r_sr[BIN_W+4*g +: 4] > BCD_MAX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_bin_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_sr    <= {i_bcd_in, {BIN_W{1'b0}}};
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt <= '0;
          if (|w_bad) begin
            r_err     <= 1'b1;
            r_bin_out <= '0;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sr  <= {w_bcd_adj, w_shifted[BIN_W-1:0]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_bin_out <= w_shifted[BIN_W-1:0];
            r_err     <= 1'b0;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_DONE);
  assign o_err     = r_err;
  assign o_bin_out = r_bin_out;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed and random stimulus for bcd_to_bin_seq, checked against an arithmetic reference model.
module tb_bcd_to_bin_seq;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [15:0]       bcd;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [BIN_W-1:0]  o_bin_out;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin_seq #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_bcd_in  (bcd),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_bin_out (o_bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_val(input logic [15:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v += int'(b[4*i +: 4]) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic bit ref_err(input logic [15:0] b);
    bit e = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts rising edges until done is seen; returns max+1 when it never arrives.
  task automatic wait_done(input int max, output int k);
    k = 0;
    while (k <= max) begin
      @(posedge clk);
      #1;
      k++;
      if (o_done) return;
    end
  endtask

  task automatic convert(input logic [15:0] b);
    int  k;
    int  exp_v;
    bit  exp_e;
    exp_e = ref_err(b);
    exp_v = exp_e ? 0 : ref_val(b);
    @(negedge clk);
    bcd   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcd   = 16'($urandom);
    check("busy_after_start", 32'(o_busy), 32'd1);
    wait_done(40, k);
    check("latency", 32'(k), exp_e ? 32'd1 : 32'(BIN_W + 1));
    check("bin_out", 32'(o_bin_out), 32'(exp_v));
    check("err", 32'(o_err), 32'(exp_e));
    check("busy_at_done", 32'(o_busy), 32'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("idle_after_done", 32'(o_busy), 32'd0);
    check("bin_out_hold", 32'(o_bin_out), 32'(exp_v));
  endtask

  initial begin
    int          k;
    int          seen;
    logic [15:0] b;

    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_bin", 32'(o_bin_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(16'h9999);
    convert(16'h0000);
    convert(16'h0042);
    convert(16'h00A5);
    convert(16'h0025);
    convert(16'hF000);
    convert(16'h9000);
    convert(16'h0009);

    // Start held high: back-to-back conversions, input changed mid-flight.
    @(negedge clk);
    bcd   = 16'h1234;
    start = 1'b1;
    wait_done(40, k);
    check("hold_first_bin", 32'(o_bin_out), 32'd1234);
    repeat (5) @(posedge clk);
    #1;
    bcd = 16'h5678;
    wait_done(40, k);
    check("b2b_period", 32'(k + 5), 32'd17);
    check("hold_second_bin", 32'(o_bin_out), 32'd1234);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hold_done_low", 32'(o_done), 32'd0);
    check("hold_idle", 32'(o_busy), 32'd0);

    // Reset during the fifth SHIFT cycle.
    @(negedge clk);
    bcd   = 16'h0777;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_err", 32'(o_err), 32'd0);
    check("abort_bin", 32'(o_bin_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (o_done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    convert(16'h0100);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 16'($urandom);
      end else begin
        for (int d = 0; d < NUM_DIGITS; d++)
          b[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      convert(b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
